// File: rtl/issue_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_hazard_ctrl_pkg
// Shared encodings for the issue/hazard controller:
//   - unit_sel_e    : target execution unit of the instruction in ID
//   - stall_cause_e : reason reported on stall_cause_o
//   - state_t       : issue FSM state (ST_RUN, ST_FENCE_INV)
//   - unit_is_ready : maps unit_sel onto the unit_ready vector
// -----------------------------------------------------------------------------
package issue_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    UNIT_NONE    = 2'd0,  // ALU or no execution unit, single cycle
    UNIT_MUL_DIV = 2'd1,
    UNIT_FPU     = 2'd2,
    UNIT_LSU     = 2'd3
  } unit_sel_e;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_RAW      = 3'd1,
    CAUSE_WAW      = 3'd2,
    CAUSE_UNIT     = 3'd3,
    CAUSE_OUT_FULL = 3'd4,
    CAUSE_FENCE    = 3'd5
  } stall_cause_e;

  // FSM states kept as plain constants so older code can compare raw bits.
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN       = 1'b0;
  localparam state_t ST_FENCE_INV = 1'b1;

  // Ready bit of the selected unit; the ALU is always ready.
  function automatic logic unit_is_ready(input logic [1:0] sel, input logic [2:0] ready);
    case (sel)
      UNIT_MUL_DIV: return ready[0];
      UNIT_FPU:     return ready[1];
      UNIT_LSU:     return ready[2];
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/issue_hazard_ctrl_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// 32-entry busy vector for one register file.
//   clk, rst_n          : clock, asynchronous active-low reset
//   set_en / set_idx    : mark a destination busy (long op issued)
//   clr_en / clr_idx    : clear a busy bit (long op completed)
//   look_idx / look_busy: NLOOK combinational lookups of the registered vector
// A set and a clear of the same bit in one cycle leaves the bit set, because
// the new producer is still outstanding. With ZERO_REG the entry 0 is
// hardwired to not-busy (integer x0).
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NLOOK    = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [4:0]            set_idx,
  input  logic                  clr_en,
  input  logic [4:0]            clr_idx,
  input  logic [NLOOK-1:0][4:0] look_idx,
  output logic [NLOOK-1:0]      look_busy
);

  logic [31:0] busy_reg;
  logic [31:0] busy_next;

  always_comb begin
    busy_next = busy_reg;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;  // applied last: set wins
    if (ZERO_REG) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLOOK; gi++) begin : g_look
      assign look_busy[gi] = busy_reg[look_idx[gi]];
    end
  endgenerate

endmodule

// File: rtl/issue_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// issue_hazard_ctrl
// Issue controller between Decode (ID) and the execution units. Tracks the
// destinations of long-latency ops in flight, stalls ID on RAW/WAW hazards,
// busy units or a full outstanding count, flushes ID on a branch redirect and
// sequences fence drain followed by a one-cycle fetch invalidate.
//
// Build option: HAZARD_CTRL_FP_SB_EN
//   defined   : an FP scoreboard is tracked; FP sources/destinations checked.
//   undefined : integer-only; FP-flagged sources never stall, FP completions
//               only decrement the outstanding count, freg_wr_en_i is unused.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   dec_valid_i                  ID holds a valid instruction
//   rs1_i, rs2_i, rs3_i          source indices; src_used_i / src_fp_i flags
//   rd_i, reg_wr_en_i, freg_wr_en_i  destination and int/FP write enables
//   unit_sel_i, unit_ready_i     target unit and MUL_DIV/FPU/LSU ready bits
//   fence_i                      instruction in ID is a fence
//   wb_valid_i, wb_is_f_i, wb_rd_i   long-op completion
//   redirect_i                   branch mispredict resolved in EX
//   id_en_o, id_clear_o          ID register enable / clear
//   issue_o                      instruction leaves ID this cycle
//   fetch_inv_o                  fetch invalidate pulse
//   stall_cause_o                reason for the current stall (0 = none)
// -----------------------------------------------------------------------------
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int MAX_OUT   = 4,    // 1..15, fits the 4-bit outstanding counter
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_valid_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rs3_i,
  input  logic [2:0] src_used_i,
  input  logic [2:0] src_fp_i,
  input  logic [4:0] rd_i,
  input  logic       reg_wr_en_i,
  input  logic       freg_wr_en_i,
  input  logic [1:0] unit_sel_i,
  input  logic [2:0] unit_ready_i,
  input  logic       fence_i,
  input  logic       wb_valid_i,
  input  logic       wb_is_f_i,
  input  logic [4:0] wb_rd_i,
  input  logic       redirect_i,
  output logic       id_en_o,
  output logic       id_clear_o,
  output logic       issue_o,
  output logic       fetch_inv_o,
  output logic [2:0] stall_cause_o
);

  state_t       state_reg, state_next;
  logic [3:0]   out_cnt_reg, out_cnt_next;
  stall_cause_e cause;

  logic [3:0][4:0] look_idx;   // entries 0..2 = rs1..rs3, entry 3 = rd
  logic [2:0][4:0] src_idx;
  logic [3:0]      int_look;
  logic [2:0]      src_busy;
  logic [2:0]      wb_hit;
  logic [2:0]      raw_src;
  logic            waw;
  logic            long_op;
  logic            unit_busy;
  logic            out_full;
  logic            fence_wait;
  logic            stall;
  logic            fence_inv_st;
  logic            cnt_inc;
  logic            cnt_dec;

  assign src_idx  = {rs3_i, rs2_i, rs1_i};
  assign look_idx = {rd_i, rs3_i, rs2_i, rs1_i};

  assign long_op  = (unit_sel_i != UNIT_NONE);

  // ---------------------------------------------------------------------------
  // Scoreboards
  // ---------------------------------------------------------------------------
  hazard_scoreboard #(.NLOOK(4), .ZERO_REG(1'b1)) u_int_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue_o & long_op & reg_wr_en_i),
    .set_idx   (rd_i),
    .clr_en    (wb_valid_i & ~wb_is_f_i),
    .clr_idx   (wb_rd_i),
    .look_idx  (look_idx),
    .look_busy (int_look)
  );

`ifdef HAZARD_CTRL_FP_SB_EN
  logic [3:0] fp_look;

  hazard_scoreboard #(.NLOOK(4), .ZERO_REG(1'b0)) u_fp_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue_o & long_op & freg_wr_en_i),
    .set_idx   (rd_i),
    .clr_en    (wb_valid_i & wb_is_f_i),
    .clr_idx   (wb_rd_i),
    .look_idx  (look_idx),
    .look_busy (fp_look)
  );

  assign waw = (reg_wr_en_i & int_look[3]) | (freg_wr_en_i & fp_look[3]);
`else
  logic unused_freg_wr;
  assign unused_freg_wr = freg_wr_en_i;

  assign waw = reg_wr_en_i & int_look[3];
`endif

  // ---------------------------------------------------------------------------
  // RAW check per source. The completing register is free this cycle when
  // bypassing, provided the completion targets the same register file.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
`ifdef HAZARD_CTRL_FP_SB_EN
      assign src_busy[gi] = src_fp_i[gi] ? fp_look[gi] : int_look[gi];
`else
      assign src_busy[gi] = ~src_fp_i[gi] & int_look[gi];
`endif
      assign wb_hit[gi]  = WB_BYPASS & wb_valid_i & (wb_rd_i == src_idx[gi]) &
                           (wb_is_f_i == src_fp_i[gi]);
      assign raw_src[gi] = src_used_i[gi] & src_busy[gi] & ~wb_hit[gi];
    end
  endgenerate

  assign unit_busy    = ~unit_is_ready(unit_sel_i, unit_ready_i);
  // A completion in this same cycle does not free a slot for the op in ID.
  assign out_full     = long_op & (out_cnt_reg == 4'(MAX_OUT));
  assign fence_wait   = fence_i & ((out_cnt_reg != 4'd0) | (state_reg != ST_RUN));
  assign fence_inv_st = (state_reg == ST_FENCE_INV);

  // Priority chain; a redirect flushes ID so nothing is reported as stalling.
  always_comb begin
    cause = CAUSE_NONE;
    if (dec_valid_i && !redirect_i) begin
      if      (|raw_src)   cause = CAUSE_RAW;
      else if (waw)        cause = CAUSE_WAW;
      else if (unit_busy)  cause = CAUSE_UNIT;
      else if (out_full)   cause = CAUSE_OUT_FULL;
      else if (fence_wait) cause = CAUSE_FENCE;
    end
  end

  assign stall         = (cause != CAUSE_NONE);
  assign stall_cause_o = cause;
  assign id_en_o       = fence_inv_st | ~stall;
  assign id_clear_o    = redirect_i | fence_inv_st;
  assign fetch_inv_o   = fence_inv_st;
  assign issue_o       = dec_valid_i & ~stall & ~redirect_i & ~fence_i & (state_reg == ST_RUN);

  // ---------------------------------------------------------------------------
  // Outstanding counter: saturates at 0, so stray completions (e.g. ops that
  // were in flight across a reset) are harmless.
  // ---------------------------------------------------------------------------
  assign cnt_inc = issue_o & long_op;
  assign cnt_dec = wb_valid_i & (out_cnt_reg != 4'd0);

  always_comb begin
    out_cnt_next = out_cnt_reg;
    if (cnt_inc && !cnt_dec)      out_cnt_next = out_cnt_reg + 4'd1;
    else if (cnt_dec && !cnt_inc) out_cnt_next = out_cnt_reg - 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Fence FSM: the drained fence is seen in RUN, the next cycle pulses the
  // invalidate and clears ID, then back to RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN: begin
        if (dec_valid_i && fence_i && (out_cnt_reg == 4'd0) && !redirect_i)
          state_next = ST_FENCE_INV;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      out_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      out_cnt_reg <= out_cnt_next;
    end
  end

endmodule
